// File: rtl/spi_follower_port.sv
// SPI follower (target) endpoint. Exchanges one 8- or 16-bit word per cs_n frame with an
// external leader, in any CPOL/CPHA mode. The TX word comes from a one-entry holding buffer
// loaded over a valid/ready port. The received word is held on rx_data until rx_ready accepts it.
//
// Ports:
//   clk, rst           system clock; asynchronous active-high reset
//   cfg_cpol/cpha/len16  mode and frame length, latched when a frame starts
//   sclk, cs_n, mosi   asynchronous leader pins (synchronized internally)
//   miso, miso_oe      follower data out and its pad output enable
//   tx_data/valid/ready  TX holding-buffer load port (tx_ready = buffer empty)
//   rx_data/valid/ready  last received word, held until rx_ready accepts it
//   busy               frame in progress (ACTIVE or DONE)
//   underrun, overrun, frame_err  one-clk status pulses
module spi_follower_port #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_cpol,
  input  logic        cfg_cpha,
  input  logic        cfg_len16,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        underrun,
  output logic        overrun,
  output logic        frame_err
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  logic [Stages-1:0] sclk_sync, cs_sync, mosi_sync;
  logic              sclk_prev, cs_prev, mosi_prev;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;

  // Edge pulses are registered, so mosi_prev is the mosi value aligned with each sclk pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      mosi_prev <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[Stages-2:0], sclk};
      cs_sync   <= {cs_sync[Stages-2:0], cs_n};
      mosi_sync <= {mosi_sync[Stages-2:0], mosi};
      sclk_prev <= sclk_sync[Stages-1];
      cs_prev   <= cs_sync[Stages-1];
      mosi_prev <= mosi_sync[Stages-1];
      sclk_rise <= sclk_sync[Stages-1] & ~sclk_prev;
      sclk_fall <= ~sclk_sync[Stages-1] & sclk_prev;
      cs_rise   <= cs_sync[Stages-1] & ~cs_prev;
      cs_fall   <= ~cs_sync[Stages-1] & cs_prev;
    end
  end

  state_e      state_q;
  logic        cpol_q, cpha_q, len16_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] tx_buf_q;
  logic [15:0] tx_shift_q;
  logic [15:0] rx_shift_q;

  logic        lead_edge, trail_edge, sample_edge, shift_edge, last_bit;
  logic [15:0] rx_next, start_word;

  always_comb begin
    lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trail_edge : lead_edge;
    shift_edge  = cpha_q ? lead_edge : trail_edge;
    last_bit    = (bit_cnt_q == (len16_q ? 5'd15 : 5'd7));
    rx_next     = {rx_shift_q[14:0], mosi_prev};
    // Outgoing word is left-justified so miso is always taken from bit 15.
    if (tx_ready) begin
      start_word = '0;
    end else begin
      start_word = cfg_len16 ? tx_buf_q : {tx_buf_q[7:0], 8'h00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      len16_q    <= 1'b0;
      bit_cnt_q  <= '0;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      tx_ready   <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tx_valid && tx_ready) begin
        tx_buf_q <= tx_data;
        tx_ready <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q    <= StActive;
            cpol_q     <= cfg_cpol;
            cpha_q     <= cfg_cpha;
            len16_q    <= cfg_len16;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            busy       <= 1'b1;
            miso_oe    <= 1'b1;
            // A full buffer is consumed; an empty one sends zeros.
            if (tx_ready) underrun <= 1'b1;
            else          tx_ready <= 1'b1;
            if (!cfg_cpha) begin
              miso       <= start_word[15];
              tx_shift_q <= {start_word[14:0], 1'b0};
            end else begin
              miso       <= 1'b0;
              tx_shift_q <= start_word;
            end
          end
        end
        StActive: begin
          if (cs_rise) begin
            state_q   <= StIdle;
            frame_err <= 1'b1;
            busy      <= 1'b0;
            miso_oe   <= 1'b0;
            miso      <= 1'b0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_next;
            bit_cnt_q  <= bit_cnt_q + 5'd1;
            if (last_bit) begin
              state_q  <= StDone;
              rx_data  <= len16_q ? rx_next : {8'h00, rx_next[7:0]};
              rx_valid <= 1'b1;
              overrun  <= rx_valid & ~rx_ready;
            end
          end else if (shift_edge) begin
            miso       <= tx_shift_q[15];
            tx_shift_q <= {tx_shift_q[14:0], 1'b0};
          end
        end
        StDone: begin
          if (cs_rise) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_follower_port.sv
module tb_spi_follower_port;

  localparam int unsigned SYNC = 2;
  localparam int H = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_len16 = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        busy, underrun, overrun, frame_err;

  always #5 clk = ~clk;

  spi_follower_port #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_len16(cfg_len16),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .underrun(underrun), .overrun(overrun), .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Status pulse counters and a count of pulses wider than one clk.
  int   und_cnt = 0, ovr_cnt = 0, ferr_cnt = 0, wide_cnt = 0;
  logic und_p = 1'b0, ovr_p = 1'b0, ferr_p = 1'b0;
  always @(negedge clk) begin
    und_p  <= underrun;
    ovr_p  <= overrun;
    ferr_p <= frame_err;
    if (underrun)  und_cnt  <= und_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((underrun && und_p) || (overrun && ovr_p) || (frame_err && ferr_p))
      wide_cnt <= wide_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [15:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    wait_neg(1);
    tx_valid = 1'b0;
    wait_neg(1);
  endtask

  task automatic accept_rx();
    rx_ready = 1'b1;
    wait_neg(1);
    rx_ready = 1'b0;
    wait_neg(1);
  endtask

  // Leader model: drives one frame of nbits, returns the bits seen on miso (right-justified)
  // and rx_valid/rx_data sampled SYNC+2 clks after the Nth sampling edge.
  task automatic frame(input logic cpol, input logic cpha, input logic len16,
                       input logic [15:0] mosi_w, input int nbits,
                       output logic [15:0] miso_w, output logic v_at, output logic [15:0] d_at);
    int n;
    logic [15:0] mo;
    n      = len16 ? 16 : 8;
    mo     = mosi_w << (16 - n);
    miso_w = '0;
    v_at   = 1'b0;
    d_at   = '0;
    cfg_cpol  = cpol;
    cfg_cpha  = cpha;
    cfg_len16 = len16;
    sclk = cpol;
    wait_neg(6);
    if (!cpha) begin
      mosi = mo[15];
      mo   = mo << 1;
    end
    cs_n = 1'b0;
    wait_neg(H);
    // Configuration is already latched; changing it now must not matter.
    cfg_cpol  = 1'($urandom);
    cfg_cpha  = 1'($urandom);
    cfg_len16 = 1'($urandom);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sclk   = ~sclk;
        miso_w = {miso_w[14:0], miso};
        if (i == n - 1) begin
          wait_neg(SYNC + 2);
          v_at = rx_valid;
          d_at = rx_data;
          wait_neg(H - SYNC - 2);
        end else begin
          wait_neg(H);
        end
        sclk = ~sclk;
        mosi = mo[15];
        mo   = mo << 1;
        wait_neg(H);
      end else begin
        sclk = ~sclk;
        mosi = mo[15];
        mo   = mo << 1;
        wait_neg(H);
        miso_w = {miso_w[14:0], miso};
        sclk   = ~sclk;
        if (i == n - 1) begin
          wait_neg(SYNC + 2);
          v_at = rx_valid;
          d_at = rx_data;
          wait_neg(H - SYNC - 2);
        end else begin
          wait_neg(H);
        end
      end
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_neg(H);
  endtask

  typedef struct {
    logic        cpol, cpha, len16, load;
    logic [15:0] tx, mosi_w, exp_miso, exp_rx;
    int          exp_und;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] mr, d;
  logic        v;
  int          u0, o0, f0;
  logic        pending;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h005A, 16'h0096, 16'h0000, 16'h0096, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hABCD, 16'hFF81, 16'h00CD, 16'h0081, 0};

    wait_neg(3);
    check("reset_outputs",
          {8'h0, miso, miso_oe, tx_ready, rx_valid, busy, underrun, overrun, frame_err, rx_data},
          {8'h0, 8'b0010_0000, 16'h0000});
    rst = 1'b0;
    wait_neg(4);

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].load) begin
        load_tx(vecs[k].tx);
        check("vec_tx_ready_low", {31'h0, tx_ready}, 32'h0);
      end
      u0 = und_cnt;
      frame(vecs[k].cpol, vecs[k].cpha, vecs[k].len16, vecs[k].mosi_w,
            vecs[k].len16 ? 16 : 8, mr, v, d);
      check("vec_miso_word", {16'h0, mr}, {16'h0, vecs[k].exp_miso});
      check("vec_rx_on_time", {15'h0, v, d}, {15'h0, 1'b1, vecs[k].exp_rx});
      check("vec_underrun", und_cnt - u0, vecs[k].exp_und);
      check("vec_held", {14'h0, tx_ready, rx_valid, rx_data}, {14'h0, 2'b11, vecs[k].exp_rx});
      accept_rx();
      check("vec_rx_cleared", {31'h0, rx_valid}, 32'h0);
    end

    // Overrun: two frames, no rx_ready in between.
    o0 = ovr_cnt;
    load_tx(16'h00AA);
    frame(1'b0, 1'b0, 1'b0, 16'h0011, 8, mr, v, d);
    load_tx(16'h0055);
    frame(1'b0, 1'b0, 1'b0, 16'h0022, 8, mr, v, d);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_rx_data", {15'h0, rx_valid, rx_data}, {15'h0, 1'b1, 16'h0022});
    accept_rx();

    // Frame error: cs_n raised after 5 of 8 bits.
    f0 = ferr_cnt;
    load_tx(16'h0077);
    frame(1'b0, 1'b0, 1'b0, 16'h00F0, 5, mr, v, d);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_state", {14'h0, rx_valid, tx_ready, rx_data}, {14'h0, 2'b01, 16'h0022});
    check("ferr_miso_bits", {16'h0, mr}, {16'h0, 16'h000E});

    // Reset mid-frame.
    load_tx(16'h3333);
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_len16 = 1'b0;
    cs_n = 1'b0;
    wait_neg(H);
    sclk = 1'b1;
    wait_neg(H);
    sclk = 1'b0;
    wait_neg(3);
    rst = 1'b1;
    wait_neg(1);
    check("midframe_reset",
          {8'h0, miso, miso_oe, tx_ready, rx_valid, busy, underrun, overrun, frame_err, rx_data},
          {8'h0, 8'b0010_0000, 16'h0000});
    cs_n = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    wait_neg(4);
    load_tx(16'h5AC3);
    frame(1'b0, 1'b0, 1'b1, 16'hC0DE, 16, mr, v, d);
    check("post_reset_miso", {16'h0, mr}, {16'h0, 16'h5AC3});
    check("post_reset_rx", {15'h0, v, d}, {15'h0, 1'b1, 16'hC0DE});
    accept_rx();

    // Randomized frames against a word-level model of the exchange.
    pending = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic cp, ch, l16, ld, acc;
      logic [15:0] tx, mw, mask;
      cp  = 1'($urandom);
      ch  = 1'($urandom);
      l16 = 1'($urandom);
      ld  = 1'($urandom);
      acc = 1'($urandom);
      tx  = 16'($urandom);
      mw  = 16'($urandom);
      mask = l16 ? 16'hFFFF : 16'h00FF;
      if (acc) begin
        accept_rx();
        pending = 1'b0;
      end
      if (ld) load_tx(tx);
      u0 = und_cnt;
      o0 = ovr_cnt;
      frame(cp, ch, l16, mw, l16 ? 16 : 8, mr, v, d);
      check("rnd_miso_word", {16'h0, mr}, {16'h0, ld ? (tx & mask) : 16'h0});
      check("rnd_rx", {15'h0, v, d}, {15'h0, 1'b1, mw & mask});
      check("rnd_underrun", und_cnt - u0, ld ? 0 : 1);
      check("rnd_overrun", ovr_cnt - o0, pending ? 1 : 0);
      check("rnd_tx_ready", {31'h0, tx_ready}, 32'h1);
      pending = 1'b1;
    end

    check("pulse_width", wide_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
